// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions for the hazard controller:
//   - ctrl_state_e : hazard-controller FSM encodings (RUN/MEMWAIT/ERROR)
//   - nop_ctrl_t   : control fields that are zeroed to turn an instruction
//                    into a NOP (RegWrite, MemWrite, CondMov)
//   - load_use_hit : load-use dependency detect between EX load and ID sources
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERROR   = 2'd2
    } ctrl_state_e;

    // Fields cleared by IFID_Flush / IDEX_Bubble / MEMWB_Bubble.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic cond_mov;
    } nop_ctrl_t;

    localparam nop_ctrl_t NOP_CTRL = '{reg_write: 1'b0, mem_write: 1'b0, cond_mov: 1'b0};

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_wr_reg,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return ex_mem_read && (ex_wr_reg != 5'd0) &&
               ((ex_wr_reg == id_rs) || (ex_wr_reg == id_rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   Clk   - clock, rising edge
//   Rst   - synchronous active-high clear
//   Inc   - count enable for this cycle
//   Count - current count value (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Count <= '0;
        end else if (Inc && (Count != {W{1'b1}})) begin
            Count <= Count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: freezes the pipeline on slow data-memory
// accesses (with timeout to a sticky error), stalls on load-use dependencies
// and flushes IF/ID on taken branches.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | normal flow; a MEM request without ready freezes and enters MEMWAIT
// MEMWAIT | waiting on data memory; frozen until DMem_Ready, times out to ERROR
// ERROR   | memory timed out; pipeline frozen, Mem_Err set, left only by Rst
//
// Ports:
//   Clk, Rst                         - clock / synchronous active-high reset
//   ID_Rs, ID_Rt                     - ID-stage source registers
//   EX_MemRead, EX_WriteRegister     - EX-stage load and its destination
//   ID_BranchTaken                   - branch resolved taken in ID
//   MEM_DMemReq, DMem_Ready          - MEM-stage access active / completes
//   PC_Write .. EXMEM_Write          - stage-register write enables
//   IFID_Flush, IDEX_Bubble,
//   MEMWB_Bubble                     - NOP insertion controls
//   Mem_Err                          - sticky memory timeout
//   Stall_Cnt                        - saturating count of stall cycles
//   Ctrl_State                       - current FSM state
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteRegister,
    input  logic             ID_BranchTaken,
    input  logic             MEM_DMemReq,
    input  logic             DMem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MEMWB_Bubble,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [1:0]       Ctrl_State
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              freeze;
    logic              load_use;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Only MEMWAIT counts; every other state holds it at zero, which also
    // gives the clear-on-entry behaviour.
    always_ff @(posedge Clk) begin
        if (Rst || (state_q != ST_MEMWAIT)) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        freeze  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (MEM_DMemReq && !DMem_Ready) begin
                    freeze  = 1'b1;
                    state_d = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                // The ready cycle itself advances the pipeline.
                if (DMem_Ready) begin
                    state_d = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign load_use = load_use_hit(EX_MemRead, EX_WriteRegister, ID_Rs, ID_Rt);

    // Priority: reset > memory freeze > load-use > branch flush.
    always_comb begin
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Bubble  = 1'b0;
        MEMWB_Bubble = 1'b0;
        if (Rst) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            IDEX_Bubble  = 1'b1;
            MEMWB_Bubble = 1'b1;
        end else if (freeze) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else if (load_use) begin
            // Hold PC/IFID so the dependent instruction re-decodes; a
            // concurrent branch is dropped and re-resolves after the stall.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (ID_BranchTaken) begin
            IFID_Flush = 1'b1;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Inc   (freeze || load_use),
        .Count (Stall_Cnt)
    );

    assign Mem_Err    = (state_q == ST_ERROR);
    assign Ctrl_State = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    // {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble}
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_FRZ  = 7'b0000_001;
    localparam logic [6:0] C_LU   = 7'b0011_010;
    localparam logic [6:0] C_BR   = 7'b1111_100;
    localparam logic [6:0] C_RST  = 7'b0000_011;

    typedef struct packed {
        logic [6:0]    ctl;
        logic          err;
        logic [CW-1:0] cnt;
        logic [1:0]    st;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [4:0]    ID_Rs, ID_Rt, EX_WriteRegister;
    logic          EX_MemRead, ID_BranchTaken, MEM_DMemReq, DMem_Ready;
    logic          PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
    logic          IFID_Flush, IDEX_Bubble, MEMWB_Bubble, Mem_Err;
    logic [CW-1:0] Stall_Cnt;
    logic [1:0]    Ctrl_State;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 Clk = ~Clk;

    hazard_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .ID_Rs            (ID_Rs),
        .ID_Rt            (ID_Rt),
        .EX_MemRead       (EX_MemRead),
        .EX_WriteRegister (EX_WriteRegister),
        .ID_BranchTaken   (ID_BranchTaken),
        .MEM_DMemReq      (MEM_DMemReq),
        .DMem_Ready       (DMem_Ready),
        .PC_Write         (PC_Write),
        .IFID_Write       (IFID_Write),
        .IDEX_Write       (IDEX_Write),
        .EXMEM_Write      (EXMEM_Write),
        .IFID_Flush       (IFID_Flush),
        .IDEX_Bubble      (IDEX_Bubble),
        .MEMWB_Bubble     (MEMWB_Bubble),
        .Mem_Err          (Mem_Err),
        .Stall_Cnt        (Stall_Cnt),
        .Ctrl_State       (Ctrl_State)
    );

    // One vector per cycle: inputs applied just after the rising edge, the
    // expected response for that cycle queued for the monitor.
    task automatic drv(input string nm, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] wr,
                       input logic br, input logic rq, input logic rd,
                       input logic [6:0] c, input logic e,
                       input logic [CW-1:0] n, input logic [1:0] s);
        exp_t x;
        @(posedge Clk);
        #1;
        Rst              = r;
        ID_Rs            = rs;
        ID_Rt            = rt;
        EX_MemRead       = mr;
        EX_WriteRegister = wr;
        ID_BranchTaken   = br;
        MEM_DMemReq      = rq;
        DMem_Ready       = rd;
        x.ctl = c;
        x.err = e;
        x.cnt = n;
        x.st  = s;
        sb_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic [6:0] c, input logic e,
                        input logic [CW-1:0] n, input logic [1:0] s);
        drv(nm, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c, e, n, s);
    endtask

    task automatic memreq(input string nm, input logic rd, input logic [6:0] c,
                          input logic e, input logic [CW-1:0] n, input logic [1:0] s);
        drv(nm, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rd, c, e, n, s);
    endtask

    // Monitor: the DUT presents a response every cycle; compare on the falling edge.
    initial begin
        exp_t  x;
        exp_t  a;
        string nm;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                x  = sb_q.pop_front();
                nm = nm_q.pop_front();
                a.ctl = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
                         IFID_Flush, IDEX_Bubble, MEMWB_Bubble};
                a.err = Mem_Err;
                a.cnt = Stall_Cnt;
                a.st  = Ctrl_State;
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL %s: got ctl=%b err=%b cnt=%0d st=%0d, want ctl=%b err=%b cnt=%0d st=%0d",
                             nm, a.ctl, a.err, a.cnt, a.st, x.ctl, x.err, x.cnt, x.st);
                end
            end
        end
    end

    initial begin
        Rst = 1'b1;
        ID_Rs = '0; ID_Rt = '0; EX_MemRead = 1'b0; EX_WriteRegister = '0;
        ID_BranchTaken = 1'b0; MEM_DMemReq = 1'b0; DMem_Ready = 1'b0;
        repeat (2) @(posedge Clk);

        drv("reset_outputs", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST, 1'b0, 4'd0, 2'd0);
        idle("idle0", C_NORM, 1'b0, 4'd0, 2'd0);

        // load-use and its boundaries
        drv("lu_rs", 1'b0, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 4'd0, 2'd0);
        idle("after_lu", C_NORM, 1'b0, 4'd1, 2'd0);
        drv("lu_r0", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 4'd1, 2'd0);
        drv("lu_rt", 1'b0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 4'd1, 2'd0);
        drv("no_memread", 1'b0, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 4'd2, 2'd0);

        // branch
        drv("branch", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR, 1'b0, 4'd2, 2'd0);
        drv("branch_lu", 1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_LU, 1'b0, 4'd2, 2'd0);
        idle("idle1", C_NORM, 1'b0, 4'd3, 2'd0);

        // memory wait: 3 freeze cycles then ready
        memreq("mw_run", 1'b0, C_FRZ, 1'b0, 4'd3, 2'd0);
        memreq("mw_wait1", 1'b0, C_FRZ, 1'b0, 4'd4, 2'd1);
        memreq("mw_wait2", 1'b0, C_FRZ, 1'b0, 4'd5, 2'd1);
        memreq("mw_ready", 1'b1, C_NORM, 1'b0, 4'd6, 2'd1);
        idle("mw_back", C_NORM, 1'b0, 4'd6, 2'd0);

        // freeze beats load-use and branch; ready cycle lets load-use through
        drv("frz_prio", 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 4'd6, 2'd0);
        drv("ready_lu", 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, C_LU, 1'b0, 4'd7, 2'd1);
        idle("idle2", C_NORM, 1'b0, 4'd8, 2'd0);
        memreq("run_ready", 1'b1, C_NORM, 1'b0, 4'd8, 2'd0);

        // timeout after 4 MEMWAIT cycles, error sticky, count saturates
        memreq("to_run", 1'b0, C_FRZ, 1'b0, 4'd8, 2'd0);
        memreq("to_w0", 1'b0, C_FRZ, 1'b0, 4'd9, 2'd1);
        memreq("to_w1", 1'b0, C_FRZ, 1'b0, 4'd10, 2'd1);
        memreq("to_w2", 1'b0, C_FRZ, 1'b0, 4'd11, 2'd1);
        memreq("to_w3", 1'b0, C_FRZ, 1'b0, 4'd12, 2'd1);
        idle("err0", C_FRZ, 1'b1, 4'd13, 2'd2);
        drv("err_ready", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_FRZ, 1'b1, 4'd14, 2'd2);
        idle("err2", C_FRZ, 1'b1, 4'd15, 2'd2);
        idle("sat0", C_FRZ, 1'b1, 4'd15, 2'd2);
        idle("sat1", C_FRZ, 1'b1, 4'd15, 2'd2);
        drv("err_rst", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST, 1'b1, 4'd15, 2'd2);
        idle("after_err_rst", C_NORM, 1'b0, 4'd0, 2'd0);

        // reset in the middle of MEMWAIT, then a fresh full timeout
        memreq("mr_run", 1'b0, C_FRZ, 1'b0, 4'd0, 2'd0);
        drv("mr_rst", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_RST, 1'b0, 4'd1, 2'd1);
        idle("mr_after", C_NORM, 1'b0, 4'd0, 2'd0);
        memreq("to2_run", 1'b0, C_FRZ, 1'b0, 4'd0, 2'd0);
        memreq("to2_w0", 1'b0, C_FRZ, 1'b0, 4'd1, 2'd1);
        memreq("to2_w1", 1'b0, C_FRZ, 1'b0, 4'd2, 2'd1);
        memreq("to2_w2", 1'b0, C_FRZ, 1'b0, 4'd3, 2'd1);
        memreq("to2_w3", 1'b0, C_FRZ, 1'b0, 4'd4, 2'd1);
        idle("to2_err", C_FRZ, 1'b1, 4'd5, 2'd2);

        repeat (4) @(posedge Clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses never compared, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16, the stall-counter width.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports ID_Rs and ID_Rt, input, 5 bits each: ID-stage source register numbers.
REQ-006 SHALL have ports EX_MemRead, input, 1 bit and EX_WriteRegister, input, 5 bits: the EX-stage load and its destination.
REQ-007 SHALL have port ID_BranchTaken, input, 1 bit: branch resolved taken in ID.
REQ-008 SHALL have ports MEM_DMemReq, input, 1 bit (MEM-stage access active) and DMem_Ready, input, 1 bit (memory completes this cycle).
REQ-009 SHALL have outputs PC_Write, IFID_Write, IDEX_Write and EXMEM_Write, 1 bit each: stage-register write enables.
REQ-010 SHALL have outputs IFID_Flush, IDEX_Bubble and MEMWB_Bubble, 1 bit each: insert a NOP by zeroing the control fields (RegWrite, MemWrite, CondMov).
REQ-011 SHALL have outputs Mem_Err, 1 bit (sticky timeout), Stall_Cnt, CNT_W bits (stall-cycle count) and Ctrl_State, 2 bits (FSM state).

Function
REQ-012 SHALL implement FSM states RUN=0, MEMWAIT=1 and ERROR=2; encoding 3 is unreachable and SHALL recover to RUN.
REQ-013 RUN SHALL go to MEMWAIT when MEM_DMemReq=1 and DMem_Ready=0; otherwise it stays in RUN.
REQ-014 MEMWAIT SHALL go to RUN in the cycle after DMem_Ready=1 is sampled, and to ERROR when the wait counter reaches MEM_TIMEOUT without DMem_Ready.
REQ-015 The wait counter SHALL clear on entry to MEMWAIT and increment once per MEMWAIT cycle.
REQ-016 ERROR SHALL be left only by Rst, and Mem_Err SHALL be 1 in ERROR.
REQ-017 A memory freeze SHALL hold when (RUN and MEM_DMemReq=1 and DMem_Ready=0), when in MEMWAIT with DMem_Ready=0, or when in ERROR.
REQ-018 During a memory freeze: all write enables 0, MEMWB_Bubble=1, IFID_Flush=0, IDEX_Bubble=0.
REQ-019 Load-use SHALL be detected when EX_MemRead=1, EX_WriteRegister≠0, and EX_WriteRegister equals ID_Rs or ID_Rt.
REQ-020 Load-use without a memory freeze: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, EXMEM_Write=1, IDEX_Write=1 (for one cycle per detection; it is combinational and Mealy).
REQ-021 ID_BranchTaken without a freeze and without load-use SHALL give IFID_Flush=1 with all enables 1.
REQ-022 Branch concurrent with load-use SHALL suppress the flush; the branch re-evaluates after the stall.
REQ-023 Priority SHALL be memory freeze > load-use > branch flush.
REQ-024 With no condition active, all enables SHALL be 1 and all flush/bubble outputs 0.
REQ-025 Stall_Cnt SHALL increment every cycle with a memory freeze or load-use, and saturate at all-ones.
REQ-026 A MEMWAIT cycle with DMem_Ready=1 SHALL NOT be a freeze: the pipeline advances in that cycle.

Reset
REQ-027 While Rst=1: outputs PC_Write/IFID_Write/IDEX_Write/EXMEM_Write=0, IFID_Flush=0, IDEX_Bubble=1, MEMWB_Bubble=1.
REQ-028 On a clock edge with Rst=1: state→RUN, wait counter=0, Stall_Cnt=0, Mem_Err=0.
REQ-029 Rst in MEMWAIT or ERROR SHALL abandon the pending access; the requester is responsible for re-issuing it.

Structure
REQ-030 State encodings and the NOP control-field definition SHALL live in the shared pipeline package.
REQ-031 The saturating stall counter SHALL be the single sub-module sat_counter, parameterised by width.

Verification
REQ-032 Load-use test: EX_MemRead=1, EX_WriteRegister=8, ID_Rs=8 → one cycle of PC_Write=0, IDEX_Bubble=1, and Stall_Cnt increments by 1. With EX_WriteRegister=0, no stall occurs.
REQ-033 Memory wait test: MEM_DMemReq=1 with DMem_Ready low for 3 cycles, then high → 3 freeze cycles, Ctrl_State=1 then 0, Stall_Cnt=3.
REQ-034 Timeout test: MEM_TIMEOUT=4 with DMem_Ready held 0 → ERROR after 4 MEMWAIT cycles, Mem_Err=1 and held; Rst clears it.
REQ-035 Branch test: ID_BranchTaken=1 alone → IFID_Flush=1. With a concurrent load-use → IFID_Flush=0 and IDEX_Bubble=1.
REQ-036 Saturation/reset test: CNT_W=4 with 20 stall cycles → Stall_Cnt=15. Rst mid-MEMWAIT → RUN and counters 0 next cycle.
